hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It consumes ID-stage decode controls, EX-stage redirects and cache stall lines. It produces per-stage write enables, flushes/bubbles and the PC source select. It owns load-use detection, cache-miss freezing, and redirect deferral while an I-cache miss is in flight.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_sat_cnt.sv | 22 ++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: PC source selects,
// redirect-deferral state and default widths.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 32;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_JAL  = 2'b01;
  localparam logic [1:0] PC_SEL_EXR  = 2'b10;
  localparam logic [1:0] PC_SEL_HOLD = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } redir_state_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
module hazard_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, cache-miss freezing and
// redirect deferral across I-cache misses. Perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_memread,
  input  logic                  id_jal,
  input  logic                  ex_redirect,
  input  logic                  icache_stall,
  input  logic                  dcache_stall,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  redir_hold_we,
  output logic                  ifid_we,
  output logic                  idex_we,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      cnt_lu,
  output logic [CNT_W-1:0]      cnt_imiss,
  output logic [CNT_W-1:0]      cnt_dmiss
);

  redir_state_t          r_state, w_state_nxt;
  logic                  r_ex_memread_q;
  logic [REG_ADDR_W-1:0] r_ex_rd_q;
  logic                  w_load_use;

  assign w_load_use = r_ex_memread_q && (r_ex_rd_q != '0) &&
                      ((id_use_rs1 && (id_rs1 == r_ex_rd_q)) ||
                       (id_use_rs2 && (id_rs2 == r_ex_rd_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_ex_memread_q <= 1'b0;
      r_ex_rd_q      <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Shadow of the ID/EX load info; a bubble never carries a load.
      if (idex_we) begin
        r_ex_memread_q <= id_memread & ~idex_bubble;
        r_ex_rd_q      <= id_rd;
      end
    end
  end

  always_comb begin
    pc_we         = 1'b0;
    pc_sel        = PC_SEL_SEQ;
    redir_hold_we = 1'b0;
    ifid_we       = 1'b0;
    idex_we       = 1'b0;
    exmem_we      = 1'b0;
    memwb_we      = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    w_state_nxt   = r_state;
    if (rst) begin
      w_state_nxt = RUN;
    end else if (dcache_stall) begin
      // Whole pipe frozen; an EX redirect is seen again once the stall ends.
      w_state_nxt = r_state;
    end else if (icache_stall) begin
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      if (ex_redirect) begin
        redir_hold_we = 1'b1;
        w_state_nxt   = PEND;
      end
    end else if (r_state == PEND) begin
      pc_we       = 1'b1;
      pc_sel      = PC_SEL_HOLD;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      w_state_nxt = RUN;
    end else if (ex_redirect) begin
      pc_we       = 1'b1;
      pc_sel      = PC_SEL_EXR;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use) begin
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
    end else if (id_jal) begin
      pc_we      = 1'b1;
      pc_sel     = PC_SEL_JAL;
      ifid_we    = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      ifid_flush = 1'b1;
    end else begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_rule_dmiss, w_rule_imiss, w_rule_lu;

  always_comb begin
    w_rule_dmiss = ~rst & dcache_stall;
    w_rule_imiss = ~rst & ~dcache_stall & icache_stall;
    w_rule_lu    = ~rst & ~dcache_stall & ~icache_stall & (r_state == RUN) &
                   ~ex_redirect & w_load_use;
  end

  hazard_sat_cnt #(.W(CNT_W)) u_cnt_lu (
    .clk(clk), .rst(rst), .i_en(w_rule_lu), .o_cnt(cnt_lu)
  );
  hazard_sat_cnt #(.W(CNT_W)) u_cnt_imiss (
    .clk(clk), .rst(rst), .i_en(w_rule_imiss), .o_cnt(cnt_imiss)
  );
  hazard_sat_cnt #(.W(CNT_W)) u_cnt_dmiss (
    .clk(clk), .rst(rst), .i_en(w_rule_dmiss), .o_cnt(cnt_dmiss)
  );
`else
  assign cnt_lu    = {CNT_W{1'b0}};
  assign cnt_imiss = {CNT_W{1'b0}};
  assign cnt_dmiss = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rh;
    logic       ifid_we;
    logic       idex_we;
    logic       exmem_we;
    logic       memwb_we;
    logic       flush;
    logic       bubble;
  } out_t;

  //                          pcwe sel   rh  ifid idex exm  mwb  fl   bub
  localparam out_t E_RST  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam out_t E_NORM = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam out_t E_LU   = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam out_t E_DST  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam out_t E_IST  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam out_t E_ISTH = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam out_t E_HOLD = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam out_t E_EXR  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam out_t E_JAL  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_memread, id_jal;
  logic          ex_redirect, icache_stall, dcache_stall;
  logic          pc_we, redir_hold_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic          ifid_flush, idex_bubble;
  logic [1:0]    pc_sel;
  logic [CW-1:0] cnt_lu, cnt_imiss, cnt_dmiss;

  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_memread(id_memread), .id_jal(id_jal),
    .ex_redirect(ex_redirect), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_we(pc_we), .pc_sel(pc_sel), .redir_hold_we(redir_hold_we),
    .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .cnt_lu(cnt_lu), .cnt_imiss(cnt_imiss), .cnt_dmiss(cnt_dmiss)
  );

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_memread = 1'b0; id_jal = 1'b0;
    ex_redirect = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
  endtask

  // Inputs are already applied; the expectation is queued, then checked mid-cycle.
  task automatic cyc(input out_t e, input string tag);
    out_t  obs, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = '{pc_we, pc_sel, redir_hold_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_bubble};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int lu, input int im, input int dm);
    logic [3*CW-1:0] obs, want;
`ifdef HAZARD_PERF_CNT_EN
    want = {lu[CW-1:0], im[CW-1:0], dm[CW-1:0]};
`else
    want = '0;
`endif
    obs = {cnt_lu, cnt_imiss, cnt_dmiss};
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed lu/imiss/dmiss %h expected %h", tag, obs, want);
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    ex_redirect = 1'b1; id_jal = 1'b1;
    cyc(E_RST, "reset_outputs");
    chk_cnt("cnt_reset", 0, 0, 0);
    rst = 1'b0; clr();
    cyc(E_NORM, "idle");

    // load-use on rs1
    id_memread = 1'b1; id_rd = 5'd5;            cyc(E_NORM, "load_rd5");
    clr(); id_use_rs1 = 1'b1; id_rs1 = 5'd5;    cyc(E_LU,   "lu_stall");
                                                cyc(E_NORM, "lu_release");
    // load-use on rs2
    clr(); id_memread = 1'b1; id_rd = 5'd7;     cyc(E_NORM, "load_rd7");
    clr(); id_use_rs2 = 1'b1; id_rs2 = 5'd7; id_rs1 = 5'd7;
                                                cyc(E_LU,   "lu_rs2");
                                                cyc(E_NORM, "lu_rs2_release");
    // matching register but not read
    clr(); id_memread = 1'b1; id_rd = 5'd9;     cyc(E_NORM, "load_rd9");
    clr(); id_rs1 = 5'd9; id_use_rs2 = 1'b1; id_rs2 = 5'd3;
                                                cyc(E_NORM, "lu_unused_src");
    // x0 destination never stalls
    clr(); id_memread = 1'b1; id_rd = 5'd0;     cyc(E_NORM, "load_rd0");
    clr(); id_use_rs1 = 1'b1; id_rs1 = 5'd0;    cyc(E_NORM, "lu_x0");

    // D-cache freeze with a pending EX redirect
    clr(); dcache_stall = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cyc(E_DST, "dstall");
    dcache_stall = 1'b0;                        cyc(E_EXR,  "dstall_redir");
    clr();                                      cyc(E_NORM, "after_dstall");

    // I-cache miss with a redirect pulse in cycle 2
    clr(); icache_stall = 1'b1;                 cyc(E_IST,  "istall_c1");
    ex_redirect = 1'b1;                         cyc(E_ISTH, "istall_hold");
    ex_redirect = 1'b0;                         cyc(E_IST,  "istall_c3");
                                                cyc(E_IST,  "istall_c4");
    clr();                                      cyc(E_HOLD, "pend_release");
                                                cyc(E_NORM, "after_hold");

    // a redirect asserted during PEND is dropped
    clr(); icache_stall = 1'b1; ex_redirect = 1'b1; cyc(E_ISTH, "hold2");
    clr(); ex_redirect = 1'b1;                  cyc(E_HOLD, "pend_vs_redir");
    clr();                                      cyc(E_NORM, "redir_dropped");

    // D-cache freeze keeps PEND
    clr(); icache_stall = 1'b1; ex_redirect = 1'b1; cyc(E_ISTH, "hold3");
    clr(); dcache_stall = 1'b1;                 cyc(E_DST,  "dstall_in_pend");
    clr();                                      cyc(E_HOLD, "pend_after_dstall");
                                                cyc(E_NORM, "after_hold3");

    // redirect beats load-use and its bubble clears the hazard
    clr(); id_memread = 1'b1; id_rd = 5'd4;     cyc(E_NORM, "load_rd4");
    clr(); id_use_rs1 = 1'b1; id_rs1 = 5'd4; ex_redirect = 1'b1;
                                                cyc(E_EXR,  "redir_over_lu");
    ex_redirect = 1'b0;                         cyc(E_NORM, "lu_cleared_by_flush");

    // JAL, and load-use beating JAL
    clr(); id_jal = 1'b1;                       cyc(E_JAL,  "jal");
    clr(); id_memread = 1'b1; id_rd = 5'd6;     cyc(E_NORM, "load_rd6");
    clr(); id_jal = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd6;
                                                cyc(E_LU,   "lu_over_jal");
                                                cyc(E_JAL,  "jal_after_lu");

    // D-cache freeze holds the load shadow
    clr(); id_memread = 1'b1; id_rd = 5'd8;     cyc(E_NORM, "load_rd8");
    clr(); id_use_rs1 = 1'b1; id_rs1 = 5'd8; dcache_stall = 1'b1;
                                                cyc(E_DST,  "dstall_lu_pending");
    dcache_stall = 1'b0;                        cyc(E_LU,   "lu_after_dstall");
                                                cyc(E_NORM, "lu_after_dstall_rel");

    // reset discards a held redirect
    clr(); icache_stall = 1'b1; ex_redirect = 1'b1; cyc(E_ISTH, "hold4");
    clr(); rst = 1'b1;                          cyc(E_RST,  "rst_in_pend");
    rst = 1'b0;                                 cyc(E_NORM, "rst_drops_hold");
    chk_cnt("cnt_after_rst", 0, 0, 0);

    // counter activity and D-miss saturation
    clr(); icache_stall = 1'b1;                 cyc(E_IST,  "cnt_imiss1");
                                                cyc(E_IST,  "cnt_imiss2");
    clr(); dcache_stall = 1'b1;                 cyc(E_DST,  "cnt_dmiss1");
    clr(); id_memread = 1'b1; id_rd = 5'd2;     cyc(E_NORM, "load_rd2");
    clr(); id_use_rs1 = 1'b1; id_rs1 = 5'd2;    cyc(E_LU,   "cnt_lu1");
    clr();                                      cyc(E_NORM, "cnt_idle");
    chk_cnt("cnt_counts", 1, 2, 1);
    dcache_stall = 1'b1;
    for (int i = 0; i < 16; i++) cyc(E_DST, "dstall_sat");
    clr();
    chk_cnt("cnt_saturate", 1, 2, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
